// File: rtl/axil_to_apb_bridge_pkg.sv
// ============================================================================
// Module  : axil_to_apb_pkg
// Brief   : Shared state encoding and response codes for the AXI-Lite to APB bridge.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package axil_to_apb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

`default_nettype wire

// File: rtl/axil_to_apb_bridge.sv
// ============================================================================
// Module  : axil_to_apb_bridge
// Brief   : AXI4-Lite slave to APB4 master, one transaction at a time, with
//           fair read/write arbitration and an ACCESS-phase timeout.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module axil_to_apb_bridge
    import axil_to_apb_pkg::*;
#(
    parameter int G_ADDR_WIDTH = 4,
    parameter int G_TIMEOUT    = 16
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [G_ADDR_WIDTH-1:0] s_axil_awaddr,
    input  logic [2:0]              s_axil_awprot,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    input  logic [31:0]             s_axil_wdata,
    input  logic [3:0]              s_axil_wstrb,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    output logic [1:0]              s_axil_bresp,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    input  logic [G_ADDR_WIDTH-1:0] s_axil_araddr,
    input  logic [2:0]              s_axil_arprot,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    output logic [31:0]             s_axil_rdata,
    output logic [1:0]              s_axil_rresp,

    output logic                    m_apb_psel,
    output logic                    m_apb_penable,
    output logic                    m_apb_pwrite,
    output logic [2:0]              m_apb_pprot,
    output logic [G_ADDR_WIDTH-1:0] m_apb_paddr,
    output logic [31:0]             m_apb_pwdata,
    output logic [3:0]              m_apb_pstrb,
    input  logic                    m_apb_pready,
    input  logic [31:0]             m_apb_prdata,
    input  logic                    m_apb_pslverr
);

    localparam int                c_cnt_w    = $clog2(G_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(G_TIMEOUT - 1);

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic                      r_last_was_write;
    logic                      r_write;
    logic [c_cnt_w-1:0]        r_cnt;
    logic [G_ADDR_WIDTH-1:0]   r_paddr;
    logic [2:0]                r_pprot;
    logic [31:0]               r_pwdata;
    logic [3:0]                r_pstrb;
    logic [31:0]               r_rdata;
    logic [1:0]                r_resp;

    logic                      w_grant_wr;
    logic                      w_grant_rd;
    logic                      w_timeout;
    logic                      w_resp_done;

    // Grants are combinational so the handshake and capture share one cycle;
    // qualifying with rst keeps ready low while reset is being applied.
    always_comb begin
        w_grant_wr  = 1'b0;
        w_grant_rd  = 1'b0;
        w_timeout   = (r_cnt == c_cnt_last);
        w_resp_done = r_write ? s_axil_bready : s_axil_rready;
        w_state_nxt = r_state;

        if (r_state == ST_IDLE && rst) begin
            w_grant_wr = s_axil_awvalid && s_axil_wvalid &&
                         (!s_axil_arvalid || !r_last_was_write);
            w_grant_rd = s_axil_arvalid && !w_grant_wr;
        end

        unique case (r_state)
            ST_IDLE:   if (w_grant_wr || w_grant_rd) w_state_nxt = ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (m_apb_pready || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP:   if (w_resp_done) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase

        s_axil_awready = w_grant_wr;
        s_axil_wready  = w_grant_wr;
        s_axil_arready = w_grant_rd;
        m_apb_psel     = (r_state == ST_SETUP) || (r_state == ST_ACCESS);
        m_apb_penable  = (r_state == ST_ACCESS);
        s_axil_bvalid  = (r_state == ST_RESP) && r_write;
        s_axil_rvalid  = (r_state == ST_RESP) && !r_write;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state          <= ST_IDLE;
            r_last_was_write <= 1'b1;
            r_write          <= 1'b0;
            r_cnt            <= '0;
            r_paddr          <= '0;
            r_pprot          <= '0;
            r_pwdata         <= '0;
            r_pstrb          <= '0;
            r_rdata          <= '0;
            r_resp           <= RESP_OKAY;
        end else begin
            r_state <= w_state_nxt;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant_wr || w_grant_rd) begin
                        r_write  <= w_grant_wr;
                        r_paddr  <= w_grant_wr ? s_axil_awaddr : s_axil_araddr;
                        r_pprot  <= w_grant_wr ? s_axil_awprot : s_axil_arprot;
                        r_pwdata <= w_grant_wr ? s_axil_wdata  : 32'd0;
                        r_pstrb  <= w_grant_wr ? s_axil_wstrb  : 4'd0;
                        r_cnt    <= '0;
                    end
                end
                ST_ACCESS: begin
                    if (m_apb_pready) begin
                        r_resp <= m_apb_pslverr ? RESP_SLVERR : RESP_OKAY;
                        if (!r_write) r_rdata <= m_apb_prdata;
                    end else if (w_timeout) begin
                        r_resp  <= RESP_SLVERR;
                        r_rdata <= 32'd0;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end
                ST_RESP: begin
                    if (w_resp_done) begin
                        r_last_was_write <= r_write;
                        r_cnt            <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_apb_pwrite = r_write;
    assign m_apb_paddr  = r_paddr;
    assign m_apb_pprot  = r_pprot;
    assign m_apb_pwdata = r_pwdata;
    assign m_apb_pstrb  = r_pstrb;
    assign s_axil_rdata = r_rdata;
    assign s_axil_rresp = r_resp;
    assign s_axil_bresp = r_resp;

endmodule

`default_nettype wire

// File: tb/tb_axil_to_apb_bridge.sv
// ============================================================================
// Module  : tb_axil_to_apb_bridge
// Brief   : Directed and randomized bench for axil_to_apb_bridge with a
//           transaction-timing reference model and an APB memory slave.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axil_to_apb_bridge;

    localparam int AW = 4;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_axil_awvalid, s_axil_awready, s_axil_wvalid, s_axil_wready;
    logic [AW-1:0] s_axil_awaddr, s_axil_araddr;
    logic [2:0]    s_axil_awprot, s_axil_arprot;
    logic [31:0]   s_axil_wdata, s_axil_rdata;
    logic [3:0]    s_axil_wstrb;
    logic          s_axil_bvalid, s_axil_bready, s_axil_arvalid, s_axil_arready;
    logic          s_axil_rvalid, s_axil_rready;
    logic [1:0]    s_axil_bresp, s_axil_rresp;
    logic          m_apb_psel, m_apb_penable, m_apb_pwrite, m_apb_pready, m_apb_pslverr;
    logic [2:0]    m_apb_pprot;
    logic [AW-1:0] m_apb_paddr;
    logic [31:0]   m_apb_pwdata, m_apb_prdata;
    logic [3:0]    m_apb_pstrb;

    always #5 clk = ~clk;

    axil_to_apb_bridge #(.G_ADDR_WIDTH(AW), .G_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(s_axil_awprot),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_bresp(s_axil_bresp),
        .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
        .s_axil_araddr(s_axil_araddr), .s_axil_arprot(s_axil_arprot),
        .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready),
        .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp),
        .m_apb_psel(m_apb_psel), .m_apb_penable(m_apb_penable), .m_apb_pwrite(m_apb_pwrite),
        .m_apb_pprot(m_apb_pprot), .m_apb_paddr(m_apb_paddr), .m_apb_pwdata(m_apb_pwdata),
        .m_apb_pstrb(m_apb_pstrb), .m_apb_pready(m_apb_pready), .m_apb_prdata(m_apb_prdata),
        .m_apb_pslverr(m_apb_pslverr)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_wait(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got no handshake expected one within budget at %0t", nm, $time);
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    // APB slave: word memory indexed by paddr; pready/pslverr behaviour selected by mode variables
    logic [31:0] slave_mem [16];
    logic [31:0] model_mem [16];
    int pr_mode  = 0;   // 0 always ready, 1 random, 2 stuck low, 3 ready on 4th access cycle
    int err_mode = 0;   // 0 never, 1 always, 2 random
    int acc_run  = 0;
    int pen_cnt  = 0;

    assign m_apb_prdata = slave_mem[m_apb_paddr];

    initial begin
        m_apb_pready  = 1'b0;
        m_apb_pslverr = 1'b0;
        forever begin
            @(negedge clk);
            if (m_apb_psel && m_apb_penable) begin
                pen_cnt++;
                acc_run++;
                if (m_apb_pready && m_apb_pwrite && !m_apb_pslverr)
                    slave_mem[m_apb_paddr] = merge(slave_mem[m_apb_paddr], m_apb_pwdata, m_apb_pstrb);
            end else begin
                acc_run = 0;
            end
            @(posedge clk); #1;
            case (pr_mode)
                0:       m_apb_pready = 1'b1;
                1:       m_apb_pready = ($urandom_range(0, 2) != 0);
                2:       m_apb_pready = 1'b0;
                default: m_apb_pready = (acc_run == 3);
            endcase
            m_apb_pslverr = (err_mode == 1) ? 1'b1 :
                            (err_mode == 2) ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
    end

    // Reference model: a transaction is in flight from grant until its response
    // is taken; SETUP is the first cycle after grant, then up to TO access cycles.
    bit          chk_en = 0;
    bit          m_busy, m_in_resp, m_w, m_last_w;
    int          m_age;
    logic [3:0]  m_addr, m_strb;
    logic [2:0]  m_prot;
    logic [31:0] m_wd, m_rdata;
    logic [1:0]  m_resp;

    initial begin
        bit gw, gr, e_psel, e_pen, e_bv, e_rv;
        m_busy = 0; m_in_resp = 0; m_w = 0; m_last_w = 1; m_age = 0;
        m_addr = 0; m_strb = 0; m_prot = 0; m_wd = 0; m_rdata = 0; m_resp = 0;
        forever begin
            @(negedge clk);
            gw = !m_busy && rst && s_axil_awvalid && s_axil_wvalid && (!s_axil_arvalid || !m_last_w);
            gr = !m_busy && rst && s_axil_arvalid && !gw;
            e_psel = m_busy && !m_in_resp;
            e_pen  = e_psel && (m_age >= 2);
            e_bv   = m_in_resp && m_w;
            e_rv   = m_in_resp && !m_w;
            if (chk_en) begin
                chk("arready", 64'(s_axil_arready), 64'(gr));
                chk("awready", 64'(s_axil_awready), 64'(gw));
                chk("wready",  64'(s_axil_wready),  64'(gw));
                chk("psel",    64'(m_apb_psel),     64'(e_psel));
                chk("penable", 64'(m_apb_penable),  64'(e_pen));
                chk("pwrite",  64'(m_apb_pwrite),   64'(m_w));
                chk("paddr",   64'(m_apb_paddr),    64'(m_addr));
                chk("pprot",   64'(m_apb_pprot),    64'(m_prot));
                chk("pwdata",  64'(m_apb_pwdata),   64'(m_w ? m_wd : 32'd0));
                chk("pstrb",   64'(m_apb_pstrb),    64'(m_w ? m_strb : 4'd0));
                chk("bvalid",  64'(s_axil_bvalid),  64'(e_bv));
                chk("rvalid",  64'(s_axil_rvalid),  64'(e_rv));
                if (e_bv) chk("bresp", 64'(s_axil_bresp), 64'(m_resp));
                if (e_rv) begin
                    chk("rresp", 64'(s_axil_rresp), 64'(m_resp));
                    chk("rdata", 64'(s_axil_rdata), 64'(m_rdata));
                end
            end
            if (!rst) begin
                m_busy = 0; m_in_resp = 0; m_w = 0; m_last_w = 1; m_age = 0;
                m_addr = 0; m_strb = 0; m_prot = 0; m_wd = 0; m_rdata = 0; m_resp = 0;
            end else if (gw || gr) begin
                m_busy = 1; m_in_resp = 0; m_age = 1; m_w = gw;
                m_addr = gw ? s_axil_awaddr : s_axil_araddr;
                m_prot = gw ? s_axil_awprot : s_axil_arprot;
                m_wd   = s_axil_wdata;
                m_strb = s_axil_wstrb;
            end else if (m_busy && !m_in_resp) begin
                if (m_age >= 2 && m_apb_pready) begin
                    m_resp = m_apb_pslverr ? 2'b10 : 2'b00;
                    if (!m_w) m_rdata = model_mem[m_addr];
                    else if (!m_apb_pslverr) model_mem[m_addr] = merge(model_mem[m_addr], m_wd, m_strb);
                    m_in_resp = 1;
                end else if (m_age - 1 == TO) begin
                    m_resp = 2'b10; m_rdata = 0; m_in_resp = 1;
                end else begin
                    m_age++;
                end
            end else if (m_in_resp && (m_w ? s_axil_bready : s_axil_rready)) begin
                m_busy = 0; m_in_resp = 0; m_last_w = m_w;
            end
        end
    end

    task automatic axi_read(input logic [3:0] a, input logic [2:0] p, input int rdly,
                            output logic [31:0] d, output logic [1:0] r, output time t_hs, output time t_v);
        int n; bit hs, got;
        d = '0; r = '0; t_hs = 0; t_v = 0;
        s_axil_araddr = a; s_axil_arprot = p; s_axil_arvalid = 1'b1;
        s_axil_rready = (rdly == 0);
        hs = 0; n = 0;
        while (!hs && n < 200) begin
            @(negedge clk); hs = s_axil_arready; t_hs = $time; n++;
            @(posedge clk); #1;
        end
        s_axil_arvalid = 1'b0;
        if (!hs) begin fail_wait("ar_handshake"); s_axil_rready = 1'b0; return; end
        got = 0; n = 0;
        while (!got && n < 200) begin @(negedge clk); got = s_axil_rvalid; n++; end
        if (!got) begin fail_wait("rvalid_wait"); s_axil_rready = 1'b0; return; end
        t_v = $time; d = s_axil_rdata; r = s_axil_rresp;
        if (rdly > 0) begin repeat (rdly) @(posedge clk); #1; s_axil_rready = 1'b1; end
        @(posedge clk); #1; s_axil_rready = 1'b0;
    endtask

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                             input logic [2:0] p, input int lead, input bit w_first, input int bdly,
                             output logic [1:0] r, output time t_hs);
        int n; bit hs, got;
        r = '0; t_hs = 0;
        s_axil_awaddr = a; s_axil_wdata = d; s_axil_wstrb = s; s_axil_awprot = p;
        s_axil_bready = (bdly == 0);
        if (lead > 0) begin
            if (w_first) s_axil_wvalid = 1'b1; else s_axil_awvalid = 1'b1;
            repeat (lead) @(posedge clk); #1;
        end
        s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
        hs = 0; n = 0;
        while (!hs && n < 200) begin
            @(negedge clk); hs = s_axil_awready; t_hs = $time; n++;
            @(posedge clk); #1;
        end
        s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
        if (!hs) begin fail_wait("aw_handshake"); s_axil_bready = 1'b0; return; end
        got = 0; n = 0;
        while (!got && n < 200) begin @(negedge clk); got = s_axil_bvalid; n++; end
        if (!got) begin fail_wait("bvalid_wait"); s_axil_bready = 1'b0; return; end
        r = s_axil_bresp;
        if (bdly > 0) begin repeat (bdly) @(posedge clk); #1; s_axil_bready = 1'b1; end
        @(posedge clk); #1; s_axil_bready = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) @(posedge clk);
        #1; rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rd2;
        logic [1:0]  rr, rr2, wr;
        time         th_r, tv_r, th_w;
        int          nv, dr, dw, n;
        bit          do_r, do_w;

        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = $urandom;
            model_mem[i] = slave_mem[i];
        end
        rst = 1'b0;
        s_axil_awvalid = 0; s_axil_wvalid = 0; s_axil_arvalid = 0;
        s_axil_bready = 0; s_axil_rready = 0;
        s_axil_awaddr = 0; s_axil_araddr = 0; s_axil_awprot = 0; s_axil_arprot = 0;
        s_axil_wdata = 0; s_axil_wstrb = 0;

        @(posedge clk); #1; chk_en = 1;
        @(posedge clk); @(negedge clk);
        chk("reset_psel",   64'(m_apb_psel),    64'(0));
        chk("reset_pen",    64'(m_apb_penable), 64'(0));
        chk("reset_bvalid", 64'(s_axil_bvalid), 64'(0));
        chk("reset_rvalid", 64'(s_axil_rvalid), 64'(0));
        chk("reset_paddr",  64'(m_apb_paddr),   64'(0));
        @(posedge clk); #1; rst = 1'b1;

        // Write then read back through the slave
        axi_write(4'h4, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0, 0, wr, th_w);
        chk("wr4_bresp", 64'(wr), 64'(2'b00));
        chk("wr4_slave_mem", 64'(slave_mem[4]), 64'(32'hDEADBEEF));
        axi_read(4'h4, 3'b000, 0, rd, rr, th_r, tv_r);
        chk("rd4_rdata", 64'(rd), 64'(32'hDEADBEEF));
        chk("rd4_rresp", 64'(rr), 64'(2'b00));
        chk("rd4_latency_ns", 64'(tv_r - th_r), 64'(30));

        // Three wait states
        pr_mode = 3; pen_cnt = 0;
        axi_read(4'h8, 3'b010, 0, rd, rr, th_r, tv_r);
        chk("rd8_wait_penable_cycles", 64'(pen_cnt), 64'(4));
        chk("rd8_wait_rdata", 64'(rd), 64'(slave_mem[8]));
        pr_mode = 0;

        // Slave error on write, then a normal read of the same word
        err_mode = 1;
        axi_write(4'hC, 32'h12345678, 4'hF, 3'b001, 0, 0, 0, wr, th_w);
        chk("wrC_err_bresp", 64'(wr), 64'(2'b10));
        err_mode = 0;
        axi_read(4'hC, 3'b000, 0, rd, rr, th_r, tv_r);
        chk("rdC_after_err_rresp", 64'(rr), 64'(2'b00));
        chk("rdC_unwritten", 64'(rd == 32'h12345678), 64'(0));

        // Timeout with pready stuck low
        pr_mode = 2; pen_cnt = 0;
        axi_read(4'h8, 3'b000, 0, rd, rr, th_r, tv_r);
        chk("timeout_penable_cycles", 64'(pen_cnt), 64'(TO));
        chk("timeout_rresp", 64'(rr), 64'(2'b10));
        chk("timeout_rdata", 64'(rd), 64'(0));
        pr_mode = 0;

        // Response back-pressure with a write waiting behind it
        fork
            axi_read(4'h4, 3'b000, 5, rd, rr, th_r, tv_r);
            begin repeat (3) @(posedge clk); #1; axi_write(4'h8, 32'hA5A5_0F0F, 4'h5, 3'b100, 0, 0, 0, wr, th_w); end
        join
        chk("bp_write_after_read", 64'(th_w > tv_r + 40), 64'(1));

        // Arbitration: read wins after reset, write wins after a lone read
        do_reset(2);
        fork
            axi_read(4'h0, 3'b000, 0, rd, rr, th_r, tv_r);
            axi_write(4'h0, 32'h0BAD_F00D, 4'hF, 3'b000, 0, 0, 0, wr, th_w);
        join
        chk("arb1_read_first", 64'(th_r < th_w), 64'(1));
        axi_read(4'h4, 3'b000, 0, rd, rr, th_r, tv_r);
        fork
            axi_read(4'h0, 3'b000, 0, rd2, rr2, th_r, tv_r);
            axi_write(4'h4, 32'h1111_2222, 4'hF, 3'b000, 0, 0, 0, wr, th_w);
        join
        chk("arb2_write_first", 64'(th_w < th_r), 64'(1));
        chk("arb2_read_sees_first_write", 64'(rd2), 64'(32'h0BAD_F00D));

        // Lone AW and lone W must wait for their partner
        axi_write(4'h8, 32'hCAFE_0001, 4'hF, 3'b000, 3, 0, 0, wr, th_w);
        axi_write(4'h8, 32'hCAFE_0002, 4'h3, 3'b000, 2, 1, 1, wr, th_w);

        // Reset during ACCESS aborts without a response
        pr_mode = 2;
        s_axil_awaddr = 4'h4; s_axil_wdata = 32'h7777_7777; s_axil_wstrb = 4'hF;
        s_axil_awvalid = 1; s_axil_wvalid = 1; s_axil_bready = 1;
        n = 0;
        do begin @(negedge clk); nv = int'(s_axil_awready); n++; @(posedge clk); #1; end
        while (nv == 0 && n < 50);
        s_axil_awvalid = 0; s_axil_wvalid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!m_apb_penable && n < 50);
        @(posedge clk); #1; rst = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        @(negedge clk);
        chk("midreset_psel", 64'(m_apb_psel), 64'(0));
        nv = 0;
        repeat (10) begin @(negedge clk); if (s_axil_bvalid || s_axil_rvalid) nv++; end
        chk("midreset_no_response", 64'(nv), 64'(0));
        @(posedge clk); #1;
        s_axil_bready = 0; pr_mode = 0;

        // Randomized traffic with contention, wait states, errors and timeouts
        err_mode = 2;
        for (int i = 0; i < 150; i++) begin
            pr_mode = ($urandom_range(0, 9) == 0) ? 2 : int'($urandom_range(0, 1));
            do_r = ($urandom_range(0, 3) != 0);
            do_w = ($urandom_range(0, 3) != 0);
            if (!do_r && !do_w) do_r = 1;
            dr = (do_r && $urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3)) : 0;
            dw = (do_w && $urandom_range(0, 1) == 0) ? int'($urandom_range(1, 3)) : 0;
            fork
                if (do_r) begin
                    if (dr > 0) begin repeat (dr) @(posedge clk); #1; end
                    axi_read(4'($urandom), 3'($urandom), int'($urandom_range(0, 3)), rd, rr, th_r, tv_r);
                end
                if (do_w) begin
                    if (dw > 0) begin repeat (dw) @(posedge clk); #1; end
                    axi_write(4'($urandom), $urandom, 4'($urandom), 3'($urandom),
                              int'($urandom_range(0, 2)), bit'($urandom_range(0, 1)),
                              int'($urandom_range(0, 3)), wr, th_w);
                end
            join
        end
        pr_mode = 0; err_mode = 0;
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
